// File: rtl/decode_dispatch_queue.sv
// decode_dispatch_queue: instruction FIFO that decodes its head entry and dispatches it to ROB plus RS or LSB
module decode_dispatch_queue #(
  parameter int ROB_WIDTH = 4,
  parameter int QUEUE_DEPTH = 4,
  localparam int ADDR_W = $clog2(QUEUE_DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 if_valid,
  input  logic [31:0]          if_pc,
  input  logic [31:0]          if_inst,
  output logic                 if_ready,
  input  logic                 rob_ready,
  input  logic [ROB_WIDTH-1:0] rob_tag,
  input  logic                 rs_ready,
  input  logic                 lsb_ready,
  output logic                 to_rob,
  output logic                 to_rs,
  output logic                 to_lsb,
  output logic [5:0]           dis_op,
  output logic [4:0]           dis_rd,
  output logic [4:0]           dis_rs1,
  output logic [4:0]           dis_rs2,
  output logic                 dis_rd_en,
  output logic                 dis_rs1_en,
  output logic                 dis_rs2_en,
  output logic [31:0]          dis_imm,
  output logic [31:0]          dis_pc,
  output logic [ROB_WIDTH-1:0] dis_tag,
  output logic                 dis_illegal
);
  logic [31:0]     pc_q [QUEUE_DEPTH];
  logic [31:0]     inst_q [QUEUE_DEPTH];
  logic [ADDR_W-1:0] head, tail;
  logic [ADDR_W:0] count;
  logic [31:0]     inst, imm;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [5:0]      op;
  logic            wr, use_rs1, use_rs2, is_ls, illegal, enq, dispatch;
  assign inst     = inst_q[head];
  assign f3       = inst[14:12];
  assign f7       = inst[31:25];
  assign if_ready = count != (ADDR_W+1)'(QUEUE_DEPTH);
  assign enq      = if_valid && if_ready;
  assign illegal  = op == 6'h3F;
  assign dispatch = count != '0 && rob_ready && (illegal || (is_ls ? lsb_ready : rs_ready));
  // decode the head entry; anything not matched stays at the ILLEGAL opcode
  always_comb begin
    op = 6'h3F;
    imm = '0;
    wr = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_ls = 1'b0;
    case (inst[6:0])
      7'b0110011: begin
        wr = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (f3)
          3'd0: op = f7 == 7'h00 ? 6'h00 : f7 == 7'h20 ? 6'h01 : 6'h3F;
          3'd1: op = f7 == 7'h00 ? 6'h05 : 6'h3F;
          3'd2: op = f7 == 7'h00 ? 6'h08 : 6'h3F;
          3'd3: op = f7 == 7'h00 ? 6'h09 : 6'h3F;
          3'd4: op = f7 == 7'h00 ? 6'h02 : 6'h3F;
          3'd5: op = f7 == 7'h00 ? 6'h06 : f7 == 7'h20 ? 6'h07 : 6'h3F;
          3'd6: op = f7 == 7'h00 ? 6'h03 : 6'h3F;
          default: op = f7 == 7'h00 ? 6'h04 : 6'h3F;
        endcase
      end
      7'b0010011: begin
        wr = 1'b1;
        use_rs1 = 1'b1;
        imm = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
        case (f3)
          3'd0: op = 6'h0A;
          3'd1: op = f7 == 7'h00 ? 6'h0E : 6'h3F;
          3'd2: op = 6'h11;
          3'd3: op = 6'h12;
          3'd4: op = 6'h0B;
          3'd5: op = f7 == 7'h00 ? 6'h0F : f7 == 7'h20 ? 6'h10 : 6'h3F;
          3'd6: op = 6'h0C;
          default: op = 6'h0D;
        endcase
      end
      7'b0000011: begin
        wr = 1'b1;
        use_rs1 = 1'b1;
        is_ls = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
        case (f3)
          3'd0: op = 6'h13;
          3'd1: op = 6'h14;
          3'd2: op = 6'h15;
          3'd4: op = 6'h16;
          3'd5: op = 6'h17;
          default: op = 6'h3F;
        endcase
      end
      7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        is_ls = 1'b1;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        op = f3 == 3'd0 ? 6'h18 : f3 == 3'd1 ? 6'h19 : f3 == 3'd2 ? 6'h1A : 6'h3F;
      end
      7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        case (f3)
          3'd0: op = 6'h1B;
          3'd1: op = 6'h1C;
          3'd4: op = 6'h1D;
          3'd5: op = 6'h1E;
          3'd6: op = 6'h1F;
          3'd7: op = 6'h20;
          default: op = 6'h3F;
        endcase
      end
      7'b1101111: begin
        wr = 1'b1;
        op = 6'h21;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b1100111: begin
        wr = 1'b1;
        use_rs1 = 1'b1;
        op = f3 == 3'd0 ? 6'h22 : 6'h3F;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0010111: begin
        wr = 1'b1;
        op = 6'h23;
        imm = {inst[31:12], 12'b0};
      end
      7'b0110111: begin
        wr = 1'b1;
        op = 6'h24;
        imm = {inst[31:12], 12'b0};
      end
      default: ;
    endcase
  end
  // FIFO storage; entries need no reset since count guards them
  always_ff @(posedge clk_in)
    if (rst_in && rdy_in && !clear && enq) begin
      pc_q[tail] <= if_pc;
      inst_q[tail] <= if_inst;
    end
  // pointers, count and registered dispatch outputs
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      {to_rob, to_rs, to_lsb} <= '0;
      {dis_op, dis_rd, dis_rs1, dis_rs2, dis_rd_en, dis_rs1_en, dis_rs2_en} <= '0;
      {dis_imm, dis_pc, dis_tag, dis_illegal} <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        {to_rob, to_rs, to_lsb} <= '0;
      end else begin
        if (enq) tail <= tail + ADDR_W'(1);
        if (dispatch) head <= head + ADDR_W'(1);
        count <= count + {{ADDR_W{1'b0}}, enq} - {{ADDR_W{1'b0}}, dispatch};
        to_rob <= dispatch;
        to_rs <= dispatch && !illegal && !is_ls;
        to_lsb <= dispatch && !illegal && is_ls;
        if (dispatch) begin
          dis_op <= op;
          dis_rd <= inst[11:7];
          dis_rs1 <= inst[19:15];
          dis_rs2 <= inst[24:20];
          dis_rd_en <= wr && !illegal && inst[11:7] != 5'd0;
          dis_rs1_en <= use_rs1 && !illegal;
          dis_rs2_en <= use_rs2 && !illegal;
          dis_imm <= imm;
          dis_pc <= pc_q[head];
          dis_tag <= rob_tag;
          dis_illegal <= illegal;
        end
      end
    end
endmodule

// File: tb/tb_decode_dispatch_queue.sv
// tb_decode_dispatch_queue: scoreboard bench for the decode/dispatch queue
module tb_decode_dispatch_queue;
  logic        clk_in = 0, rst_in = 0, rdy_in = 1, clear = 0, if_valid = 0;
  logic [31:0] if_pc = 0, if_inst = 0;
  logic        if_ready, rob_ready = 1, rs_ready = 1, lsb_ready = 1;
  logic [3:0]  rob_tag = 0;
  logic        to_rob, to_rs, to_lsb, dis_rd_en, dis_rs1_en, dis_rs2_en, dis_illegal;
  logic [5:0]  dis_op;
  logic [4:0]  dis_rd, dis_rs1, dis_rs2;
  logic [31:0] dis_imm, dis_pc;
  logic [3:0]  dis_tag;
  int total = 0, bad = 0, ndis = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] imm;
    logic        ci;
    logic        rd_en;
    logic [3:0]  tag;
    logic [1:0]  tgt;
  } exp_t;
  exp_t sb[$];

  decode_dispatch_queue #(.ROB_WIDTH(4), .QUEUE_DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .rob_ready(rob_ready), .rob_tag(rob_tag), .rs_ready(rs_ready), .lsb_ready(lsb_ready),
    .to_rob(to_rob), .to_rs(to_rs), .to_lsb(to_lsb), .dis_op(dis_op),
    .dis_rd(dis_rd), .dis_rs1(dis_rs1), .dis_rs2(dis_rs2),
    .dis_rd_en(dis_rd_en), .dis_rs1_en(dis_rs1_en), .dis_rs2_en(dis_rs2_en),
    .dis_imm(dis_imm), .dis_pc(dis_pc), .dis_tag(dis_tag), .dis_illegal(dis_illegal)
  );

  always #5 clk_in = ~clk_in;

  task automatic put(input logic [31:0] pc, input logic [31:0] inst, input logic [5:0] op,
                     input logic [31:0] imm, input logic ci, input logic rd_en,
                     input logic [3:0] tag, input logic [1:0] tgt);
    if_valid = 1;
    if_pc = pc;
    if_inst = inst;
    sb.push_back('{pc, op, imm, ci, rd_en, tag, tgt});
  endtask

  task automatic tick(input bit mon = 1'b1);
    exp_t e;
    @(posedge clk_in);
    #1;
    if (mon && to_rob) begin
      ndis++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: dispatch pc=%h op=%h with nothing expected", dis_pc, dis_op);
      end else begin
        e = sb.pop_front();
        if (dis_pc !== e.pc || dis_op !== e.op || (e.ci && dis_imm !== e.imm) || dis_rd_en !== e.rd_en ||
            dis_tag !== e.tag || to_rs !== (e.tgt == 2'd0) || to_lsb !== (e.tgt == 2'd1) ||
            dis_illegal !== (e.tgt == 2'd2)) begin
          bad++;
          $display("FAIL sb_dispatch: got pc=%h op=%h imm=%h rd_en=%b tag=%h rs=%b lsb=%b ill=%b want pc=%h op=%h imm=%h rd_en=%b tag=%h tgt=%0d",
                   dis_pc, dis_op, dis_imm, dis_rd_en, dis_tag, to_rs, to_lsb, dis_illegal,
                   e.pc, e.op, e.imm, e.rd_en, e.tag, e.tgt);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_in = 0;
    rdy_in = 0;
    tick(0);
    total++;
    if ({to_rob, to_rs, to_lsb, dis_illegal, dis_rd_en, dis_rs1_en, dis_rs2_en} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0", {to_rob, to_rs, to_lsb, dis_illegal, dis_rd_en, dis_rs1_en, dis_rs2_en});
    end
    total++;
    if (dis_op !== 6'h00 || dis_imm !== 32'h0 || dis_pc !== 32'h0 || dis_tag !== 4'h0) begin
      bad++;
      $display("FAIL reset_data: got op=%h imm=%h pc=%h tag=%h want zeros", dis_op, dis_imm, dis_pc, dis_tag);
    end
    total++;
    if (if_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_if_ready: got %b want 1", if_ready);
    end
    rst_in = 1;
    rdy_in = 1;
  endtask

  task automatic test_addi();
    rob_tag = 0;
    put(32'h1000, 32'h00500093, 6'h0A, 32'd5, 1, 1, 4'd0, 2'd0);
    tick();
    if_valid = 0;
    total++;
    if (to_rob !== 1'b0) begin
      bad++;
      $display("FAIL addi_latency: to_rob=%b one edge after accept, want 0", to_rob);
    end
    tick();
    total++;
    if (to_rob !== 1 || to_rs !== 1 || to_lsb !== 0 || dis_rd !== 5'd1 || dis_rs1_en !== 1 || dis_rs2_en !== 0) begin
      bad++;
      $display("FAIL addi_fields: got rob=%b rs=%b lsb=%b rd=%0d rs1_en=%b rs2_en=%b want 1 1 0 1 1 0",
               to_rob, to_rs, to_lsb, dis_rd, dis_rs1_en, dis_rs2_en);
    end
  endtask

  task automatic test_store();
    rob_tag = 3;
    put(32'h1004, 32'hFE20AE23, 6'h1A, 32'hFFFFFFFC, 1, 0, 4'd3, 2'd1);
    tick();
    if_valid = 0;
    tick();
    total++;
    if (to_lsb !== 1 || to_rs !== 0 || dis_rs1 !== 5'd1 || dis_rs2 !== 5'd2 || dis_rs2_en !== 1 || dis_tag !== 4'd3) begin
      bad++;
      $display("FAIL sw_fields: got lsb=%b rs=%b rs1=%0d rs2=%0d rs2_en=%b tag=%0d want 1 0 1 2 1 3",
               to_lsb, to_rs, dis_rs1, dis_rs2, dis_rs2_en, dis_tag);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    rob_tag = 1;
    put(32'h1008, 32'h008000EF, 6'h21, 32'd8, 1, 1, 4'd1, 2'd0);
    tick();
    n0 = ndis;
    put(32'h100C, 32'hFE000CE3, 6'h1B, 32'hFFFFFFF8, 1, 0, 4'd1, 2'd0);
    tick();
    if_valid = 0;
    tick();
    total++;
    if (ndis - n0 !== 2 || dis_op !== 6'h1B) begin
      bad++;
      $display("FAIL b2b_throughput: got %0d dispatches last op=%h want 2 op=1b", ndis - n0, dis_op);
    end
  endtask

  task automatic test_illegal();
    rob_tag = 2;
    put(32'h1010, 32'hFFFFFFFF, 6'h3F, 32'h0, 0, 0, 4'd2, 2'd2);
    tick();
    if_valid = 0;
    tick();
    total++;
    if (to_rob !== 1 || to_rs !== 0 || to_lsb !== 0 || dis_illegal !== 1 || dis_op !== 6'h3F) begin
      bad++;
      $display("FAIL illegal_route: got rob=%b rs=%b lsb=%b ill=%b op=%h want 1 0 0 1 3f",
               to_rob, to_rs, to_lsb, dis_illegal, dis_op);
    end
  endtask

  task automatic test_decode_mix();
    rob_tag = 6;
    put(32'h1014, 32'h12345537, 6'h24, 32'h12345000, 1, 1, 4'd6, 2'd0);
    tick();
    put(32'h1018, {7'h20, 5'd7, 5'd1, 3'd5, 5'd3, 7'h13}, 6'h10, 32'd7, 1, 1, 4'd6, 2'd0);
    tick();
    put(32'h101C, {7'h20, 5'd3, 5'd1, 3'd1, 5'd3, 7'h13}, 6'h3F, 32'h0, 0, 0, 4'd6, 2'd2);
    tick();
    put(32'h1020, {20'hABCDE, 5'd0, 7'h17}, 6'h23, 32'hABCDE000, 1, 0, 4'd6, 2'd0);
    tick();
    if_valid = 0;
    drain();
  endtask

  task automatic test_stall();
    logic [5:0] p;
    rs_ready = 0;
    rob_tag = 7;
    p = dis_op;
    put(32'h1024, {12'h7FF, 5'd0, 3'd0, 5'd5, 7'h13}, 6'h0A, 32'h7FF, 1, 1, 4'd7, 2'd0);
    tick();
    if_valid = 0;
    tick();
    tick();
    total++;
    if (to_rob !== 0 || dis_op !== p) begin
      bad++;
      $display("FAIL stall_hold: got rob=%b op=%h want 0 op=%h", to_rob, dis_op, p);
    end
    rs_ready = 1;
    drain();
  endtask

  task automatic test_full();
    rob_ready = 0;
    rob_tag = 5;
    for (int i = 0; i < 5; i++) begin
      if_valid = 1;
      if_pc = 32'h2000 + 32'(4 * i);
      if_inst = i[0] ? {12'(10 + i), 5'd1, 3'd2, 5'd2, 7'h03} : {12'(10 + i), 5'd0, 3'd0, 5'd1, 7'h13};
      total++;
      if (if_ready !== (i < 4)) begin
        bad++;
        $display("FAIL full_if_ready: entry %0d got %b want %b", i, if_ready, i < 4);
      end
      if (i < 4) sb.push_back('{if_pc, i[0] ? 6'h15 : 6'h0A, 32'(10 + i), 1'b1, 1'b1, 4'd5, i[0] ? 2'd1 : 2'd0});
      tick();
    end
    if_valid = 0;
    rob_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (to_rob !== 1) begin
        bad++;
        $display("FAIL full_consecutive: cycle %0d to_rob=%b want 1", i, to_rob);
      end
    end
    tick();
    total++;
    if (to_rob !== 0 || sb.size() != 0) begin
      bad++;
      $display("FAIL full_extra: to_rob=%b pending=%0d want 0 0", to_rob, sb.size());
    end
  endtask

  task automatic test_clear();
    rob_ready = 0;
    rob_tag = 4;
    for (int i = 0; i < 3; i++) begin
      put(32'h3000 + 32'(4 * i), 32'h00500093, 6'h0A, 32'd5, 1, 1, 4'd4, 2'd0);
      tick();
    end
    clear = 1;
    if_inst = 32'h00100113;
    tick();
    clear = 0;
    if_valid = 0;
    sb.delete();
    total++;
    if (if_ready !== 1 || to_rob !== 0) begin
      bad++;
      $display("FAIL clear_state: got if_ready=%b to_rob=%b want 1 0", if_ready, to_rob);
    end
    rob_ready = 1;
    tick();
    tick();
    total++;
    if (to_rob !== 0 || to_rs !== 0 || to_lsb !== 0) begin
      bad++;
      $display("FAIL clear_empty: got strobes %b%b%b want 000", to_rob, to_rs, to_lsb);
    end
  endtask

  task automatic test_rdy_hold();
    logic [31:0] pa;
    rob_ready = 0;
    rob_tag = 9;
    put(32'h4000, 32'h00500093, 6'h0A, 32'd5, 1, 1, 4'd9, 2'd0);
    tick();
    put(32'h4004, 32'hFE20AE23, 6'h1A, 32'hFFFFFFFC, 1, 0, 4'd9, 2'd1);
    tick();
    if_valid = 0;
    rob_ready = 1;
    tick();
    pa = dis_pc;
    rdy_in = 0;
    put(32'h4008, 32'h008000EF, 6'h21, 32'd8, 1, 1, 4'd9, 2'd0);
    void'(sb.pop_back());
    tick(0);
    tick(0);
    total++;
    if (to_rob !== 1 || to_rs !== 1 || dis_pc !== pa || dis_op !== 6'h0A) begin
      bad++;
      $display("FAIL rdy_freeze: got rob=%b rs=%b pc=%h op=%h want 1 1 %h 0a", to_rob, to_rs, dis_pc, dis_op, pa);
    end
    if_valid = 0;
    rdy_in = 1;
    tick();
    tick();
    total++;
    if (to_rob !== 0 || sb.size() != 0) begin
      bad++;
      $display("FAIL rdy_resume: to_rob=%b pending=%0d want 0 0", to_rob, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store();
    test_back_to_back();
    test_illegal();
    test_decode_mix();
    test_stall();
    test_full();
    test_clear();
    test_rdy_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_dispatch_queue.md
# decode_dispatch_queue

Parametrised front-end decode stage with an instruction buffer. It accepts fetched (pc, instruction) pairs from IF into a DEPTH-entry FIFO and decodes the head entry into the codebase's 6-bit internal opcodes. It dispatches one instruction per cycle to the ROB plus either the RS or the LSB, using per-target ready signals, and flags illegal encodings instead of silently dropping them. It sits between instruction fetch and the ROB/RS/LSB and decouples fetch from back-pressure.

## Interface
- ROB_WIDTH, 4, ROB tag width
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_W, $clog2(QUEUE_DEPTH), pointer width (derived; do not override)

- clk_in  in  1  clock; all state updates on the rising edge
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global enable; low = hold all state
- clear  in  1  flush (branch mispredict)
- if_valid  in  1  IF presents an instruction
- if_pc  in  32  PC of the instruction
- if_inst  in  32  instruction word
- if_ready  out  1  combinational: count < QUEUE_DEPTH
- rob_ready  in  1  ROB has a free slot
- rob_tag  in  ROB_WIDTH  tag of the next ROB slot
- rs_ready  in  1  RS has a free slot
- lsb_ready  in  1  LSB has a free slot
- to_rob, to_rs, to_lsb  out  1 each  registered one-cycle dispatch strobes
- dis_op  out  6  internal opcode (ADD=0x00 … LUI=0x24); ILLEGAL=0x3F
- dis_rd, dis_rs1, dis_rs2  out  5 each  register indices
- dis_rd_en, dis_rs1_en, dis_rs2_en  out  1 each  field-used flags
- dis_imm  out  32  decoded immediate
- dis_pc  out  32  instruction PC
- dis_tag  out  ROB_WIDTH  ROB tag captured at dispatch
- dis_illegal  out  1  instruction is not a supported RV32I encoding

## Operation
- FIFO: head/tail pointers of ADDR_W bits, wrap modulo QUEUE_DEPTH; count of ADDR_W+1 bits.
- Enqueue when if_valid && if_ready. There is no pass-through when full: if_ready=0 at count==QUEUE_DEPTH even if a dequeue happens the same cycle.
- Routing of the head instruction:
  - Loads and stores → ROB+LSB.
  - Illegal → ROB only, with dis_illegal=1 and dis_op=0x3F.
  - All others → ROB+RS.
- Dispatch (dequeue) requires count>0 && rob_ready && the routed target's ready (rs_ready or lsb_ready).
- On dispatch, register all dis_* fields and the strobes for the routed targets; dis_tag←rob_tag. Otherwise the strobes are 0 and the dis_* data fields hold.
- Immediates:
  - I-type, load, JALR, SLTIU: sign-extended [31:20].
  - Shifts: zero-extended [24:20].
  - S-type: sext{[31:25],[11:7]}.
  - B-type: sext{[31],[7],[30:25],[11:8],0}.
  - J-type: sext{[31],[19:12],[20],[30:21],0}.
  - U-type: {[31:12],12'b0}.
- Illegal decode: any opcode/funct3/funct7 combination outside RV32I base (excluding FENCE/SYSTEM), including shifts with a bad funct7.
- Field-used flags:
  - dis_rd_en: instruction writes rd and rd≠0.
  - dis_rs1_en: R, I, load, store, branch, JALR.
  - dis_rs2_en: R, store, branch.
- JAL produces op JAL (0x21).
- Priority: reset > rdy_in low (hold everything, strobes included; downstream is gated by the same rdy_in) > clear > enqueue/dispatch.
- Clear: empty the FIFO (head=tail=count=0), drive strobes to 0 next cycle, ignore the same-cycle if_valid.

## Timing
- Reset (rst_in=0 at an edge, regardless of rdy_in): pointers/count=0, all strobes=0, all dis_* =0, dis_op=0x00. if_ready=1 once count=0.
- Latency: an instruction accepted at edge E can dispatch at edge E+1 at the earliest, with strobes visible after E+1. Throughput is 1 per cycle.
- Simultaneous enqueue and dispatch at 0<count<QUEUE_DEPTH: count unchanged, both pointers advance.
- A stall (ready low) holds the head. The dispatch fields do not change until the next dispatch.

## Test plan
- Reset, then 0x00500093 (ADDI x1,x0,5) → after 2 edges: to_rob=to_rs=1, to_lsb=0, dis_op=0x0A, dis_rd=1, dis_imm=5, dis_rd_en=1, dis_rs2_en=0.
- 0xFE20AE23 (SW x2,-4(x1)) with rob_tag=3 → to_rob=to_lsb=1, to_rs=0, dis_op=0x1A, dis_imm=0xFFFFFFFC, dis_tag=3, dis_rd_en=0.
- 0x008000EF (JAL x1,+8) → dis_op=0x21, dis_imm=8. Then 0xFE000CE3 (BEQ x0,x0,-8) → dis_op=0x1B, dis_imm=0xFFFFFFF8, dis_rd_en=0.
- 0xFFFFFFFF → to_rob=1, to_rs=to_lsb=0, dis_illegal=1, dis_op=0x3F.
- Hold rob_ready=0 and push 5 instructions with QUEUE_DEPTH=4 → if_ready falls after the 4th, the 5th is held. Raise rob_ready → 4 dispatches in consecutive cycles, in order, with pointer wrap verified.
- Fill 3 entries, assert clear with if_valid=1 → next cycle count=0, no strobes, if_ready=1. Separately, drop rdy_in mid-stream → all outputs and pointers freeze.
